weight_loader: RTL

- Transmitter side of the weight_buffer write interface (up_vld/up_dat/up_rdy) plus its butterfly_start trigger.
- Accepts a narrow stream of fp16 weights from the DMA/memory side and packs them into full lane beats of 4*BU_PARALLELISM halves.
- Sends exactly log2(length)*depth beats, where depth = length*2/(4*BU_PARALLELISM), then pulses butterfly_start once.
- Sits between the weight DMA and weight_buffer in the NPU butterfly datapath.

---
 rtl/npu_weight_pkg.sv | 47 ++++
 rtl/weight_loader_if.sv | 26 ++
 rtl/weight_beat_packer.sv | 76 +++++++
 rtl/weight_loader.sv | 111 +++++++++++
 4 files changed

// File: rtl/npu_weight_pkg.sv
// Shared definitions for the NPU butterfly weight path (weight_loader and
// weight_buffer): geometry constants, the loader FSM state type and the
// length-derived helpers used to size a load.
//   DATA_WIDTH     bits per fp16 weight
//   BU_PARALLELISM butterfly units; LANES = 4*BU_PARALLELISM weights per beat
//   IN_WORDS       weights per input beat; R input beats form one lane beat
//   MAX_LENGTH     largest supported transform length
package npu_weight_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int BU_PARALLELISM = 4;
  localparam int LANES          = 4 * BU_PARALLELISM;
  localparam int BEAT_WIDTH     = DATA_WIDTH * LANES;
  localparam int IN_WORDS       = 4;
  localparam int IN_WIDTH       = DATA_WIDTH * IN_WORDS;
  localparam int R              = LANES / IN_WORDS;
  localparam int MAX_LENGTH     = 1024;
  localparam int LEN_W          = 16;

  // Worst case beat count: log2(MAX_LENGTH) stages of depth beats each.
  localparam int MAX_OUT   = $clog2(MAX_LENGTH) * (MAX_LENGTH * 2 / LANES);
  localparam int OUT_CNT_W = $clog2(MAX_OUT + 1);
  localparam int IN_CNT_W  = $clog2(MAX_OUT * R + 1);
  localparam int PCNT_W    = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2
  } wl_state_e;

  // Lane beats per butterfly stage.
  function automatic logic [LEN_W-1:0] depth_of(input logic [LEN_W-1:0] length);
    return LEN_W'((32'(length) * 2) / LANES);
  endfunction

  // log2 of a power-of-two length: index of the highest set bit.
  function automatic logic [4:0] stages_of(input logic [LEN_W-1:0] length);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < LEN_W; i++) begin
      if (length[i]) s = 5'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Stream bundle around weight_loader: the narrow DMA input stream
// (in_vld/in_dat/in_rdy) and the packed weight_buffer write stream
// (up_vld/up_dat/up_rdy).
//   master : the loader (consumes in_*, produces up_*)
//   slave  : the environment (DMA source and weight_buffer sink)
interface weight_loader_if;
  import npu_weight_pkg::*;

  logic                  in_vld;
  logic [IN_WIDTH-1:0]   in_dat;
  logic                  in_rdy;
  logic                  up_vld;
  logic [BEAT_WIDTH-1:0] up_dat;
  logic                  up_rdy;

  modport master (
    input  in_vld, in_dat, up_rdy,
    output in_rdy, up_vld, up_dat
  );

  modport slave (
    output in_vld, in_dat, up_rdy,
    input  in_rdy, up_vld, up_dat
  );

endinterface

// File: rtl/weight_beat_packer.sv
// Collects R narrow input beats into one full lane beat and presents it on a
// registered valid/ready output. Input beat k of a group lands in lanes
// k*IN_WORDS .. k*IN_WORDS+IN_WORDS-1.
//   clk, rst_n   clock, asynchronous active-low reset
//   in_avail_i   the loader still wants input beats
//   in_vld_i/in_dat_i/in_rdy_o   narrow input stream
//   up_vld_o/up_dat_o/up_rdy_i   packed output stream
module weight_beat_packer import npu_weight_pkg::*; (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_avail_i,
  input  logic                  in_vld_i,
  input  logic [IN_WIDTH-1:0]   in_dat_i,
  output logic                  in_rdy_o,
  output logic                  up_vld_o,
  output logic [BEAT_WIDTH-1:0] up_dat_o,
  input  logic                  up_rdy_i
);

  logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
  logic [BEAT_WIDTH-1:0] pack_q, pack_d;
  logic [BEAT_WIDTH-1:0] up_dat_q, up_dat_d;
  logic                  up_vld_q, up_vld_d;
  logic [BEAT_WIDTH-1:0] merged;
  logic                  last_word;
  logic                  slot_free;
  logic                  in_fire;

  // Only the group-completing beat needs the output slot; earlier beats of a
  // group just fill the pack register and are never back-pressured.
  assign last_word = (pcnt_q == PCNT_W'(R - 1));
  assign slot_free = !up_vld_q || up_rdy_i;
  assign in_rdy_o  = in_avail_i && (!last_word || slot_free);
  assign in_fire   = in_vld_i && in_rdy_o;

  always_comb begin
    pack_d   = pack_q;
    pcnt_d   = pcnt_q;
    up_dat_d = up_dat_q;
    up_vld_d = up_vld_q;
    merged   = pack_q;
    merged[pcnt_q * IN_WIDTH +: IN_WIDTH] = in_dat_i;

    if (up_vld_q && up_rdy_i) up_vld_d = 1'b0;

    if (in_fire) begin
      if (last_word) begin
        // A new beat loading in the accepting cycle keeps up_vld high.
        up_dat_d = merged;
        up_vld_d = 1'b1;
        pcnt_d   = '0;
      end else begin
        pack_d = merged;
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q   <= '0;
      pack_q   <= '0;
      up_dat_q <= '0;
      up_vld_q <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      pack_q   <= pack_d;
      up_dat_q <= up_dat_d;
      up_vld_q <= up_vld_d;
    end
  end

  assign up_vld_o = up_vld_q;
  assign up_dat_o = up_dat_q;

endmodule

// File: rtl/weight_loader.sv
// Weight loader: streams log2(length)*depth packed lane beats from the weight
// DMA into weight_buffer, then fires butterfly_start once.
//   clk, rst_n       clock, asynchronous active-low reset
//   length           transform length, sampled with load_start
//   load_start       one-cycle load request (ignored unless idle)
//   wl               input/output streams (master side)
//   butterfly_start  one-cycle pulse after the last beat is accepted
//   busy             high from the cycle after an accepted start through START
//   done             one-cycle pulse alongside butterfly_start
//   err              one-cycle pulse after a request with an invalid length
module weight_loader import npu_weight_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LEN_W-1:0]  length,
  input  logic              load_start,
  weight_loader_if.master   wl,
  output logic              butterfly_start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  wl_state_e              state_q, state_d;
  logic [OUT_CNT_W-1:0]   total_out_q, total_out_d;
  logic [IN_CNT_W-1:0]    total_in_q, total_in_d;
  logic [OUT_CNT_W-1:0]   out_cnt_q;
  logic [IN_CNT_W-1:0]    in_cnt_q;
  logic                   err_q, err_d;
  logic                   latch;
  logic                   len_pow2;
  logic                   len_ok;
  logic                   in_avail;
  logic                   in_fire;
  logic                   out_fire;

  assign len_pow2 = (length != '0) && ((length & (length - 1'b1)) == '0);
  assign len_ok   = len_pow2 &&
                    (length >= LEN_W'(2 * BU_PARALLELISM)) &&
                    (length <= LEN_W'(MAX_LENGTH));

  assign total_out_d = OUT_CNT_W'(stages_of(length) * depth_of(length));
  assign total_in_d  = IN_CNT_W'(total_out_d) * IN_CNT_W'(R);

  assign in_avail = (state_q == LOAD) && (in_cnt_q < total_in_q);
  assign in_fire  = wl.in_vld && wl.in_rdy;
  assign out_fire = wl.up_vld && wl.up_rdy;

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          if (len_ok) begin
            state_d = LOAD;
            latch   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (out_fire && (out_cnt_q == total_out_q - 1'b1)) state_d = START;
      end
      START:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      err_q       <= 1'b0;
      total_out_q <= '0;
      total_in_q  <= '0;
      out_cnt_q   <= '0;
      in_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (latch) begin
        total_out_q <= total_out_d;
        total_in_q  <= total_in_d;
        out_cnt_q   <= '0;
        in_cnt_q    <= '0;
      end else begin
        if (in_fire)  in_cnt_q  <= in_cnt_q + 1'b1;
        if (out_fire) out_cnt_q <= out_cnt_q + 1'b1;
      end
    end
  end

  weight_beat_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_avail_i (in_avail),
    .in_vld_i   (wl.in_vld),
    .in_dat_i   (wl.in_dat),
    .in_rdy_o   (wl.in_rdy),
    .up_vld_o   (wl.up_vld),
    .up_dat_o   (wl.up_dat),
    .up_rdy_i   (wl.up_rdy)
  );

  assign busy            = (state_q != IDLE);
  assign butterfly_start = (state_q == START);
  assign done            = (state_q == START);
  assign err             = err_q;

endmodule
